mul_pipelined: RTL and testbench

//  Parametrised, pipelined RV-M integer multiplier with valid/ready handshake, tag passthrough and flush.

---
 rtl/mul_pkg.sv | 31 +++
 rtl/mul_pipelined_core.sv | 67 ++++++
 rtl/mul_pipelined.sv | 154 +++++++++++++++
 tb/tb_mul_pipelined.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the pipelined RV-M multiplier.
// Contents: op encoding, the control payload that travels beside the operands,
// and the operand signedness decode used in stage 0.
package mul;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } op_t;

  // Per-op control that rides alongside the operands through the pipe.
  typedef struct packed {
    op_t  op;
    logic is_word;
  } ctrl_t;

  // rs1 is treated as signed for MUL, MULH and MULHSU.
  function automatic logic op_a_signed(input op_t op);
    return (op == MUL) || (op == MULH) || (op == MULHSU);
  endfunction

  // rs2 is treated as signed for MUL and MULH only.
  function automatic logic op_b_signed(input op_t op);
    return (op == MUL) || (op == MULH);
  endfunction

endpackage

// File: rtl/mul_pipelined_core.sv
// Signed (XLEN+1)x(XLEN+1) multiplier with STAGES-1 enable-gated retiming registers.
// Ports:
//   clock   rising-edge clock
//   en_i    advance enable; when low every internal register holds
//   a_i     sign-carrying extended rs1 (XLEN+1 bits)
//   b_i     sign-carrying extended rs2 (XLEN+1 bits)
//   prod_o  low 2*XLEN bits of the signed product
module mul_core #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STAGES = 3
) (
  input  logic              clock,
  input  logic              en_i,
  input  logic [XLEN:0]     a_i,
  input  logic [XLEN:0]     b_i,
  output logic [2*XLEN-1:0] prod_o
);

  localparam int unsigned PW = 2 * XLEN;

  // The low PW bits of a signed product only need operands sign-extended to PW.
  function automatic logic [PW-1:0] smul(input logic [XLEN:0] a, input logic [XLEN:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = {{(PW-XLEN-1){a[XLEN]}}, a};
    bx = {{(PW-XLEN-1){b[XLEN]}}, b};
    return ax * bx;
  endfunction

  if (STAGES == 1) begin : g_comb
    // Single stage: product feeds the output register of the top directly.
    assign prod_o = smul(a_i, b_i);
  end else begin : g_pipe
    logic [XLEN:0] a_q;
    logic [XLEN:0] b_q;
    logic [PW-1:0] p_c;

    // Operand capture is the accept-edge stage.
    always_ff @(posedge clock) begin
      if (en_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
    end

    assign p_c = smul(a_q, b_q);

    if (STAGES == 2) begin : g_direct
      assign prod_o = p_c;
    end else begin : g_retime
      logic [PW-1:0] p_q [STAGES-2];

      // Extra product registers give the synthesis tool room to retime the array.
      always_ff @(posedge clock) begin
        if (en_i) begin
          p_q[0] <= p_c;
          for (int unsigned i = 1; i < STAGES - 2; i++) begin
            p_q[i] <= p_q[i-1];
          end
        end
      end

      assign prod_o = p_q[STAGES-3];
    end
  end

endmodule

// File: rtl/mul_pipelined.sv
// Pipelined RV-M multiplier (MUL/MULH/MULHSU/MULHU plus W forms) with valid/ready,
// tag passthrough and flush. Fixed latency of STAGES edges from accept to out_valid.
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   flush               kill every in-flight op at this edge
//   in_valid/in_ready   issue handshake (in_ready is combinational)
//   in_op, in_is_word   operation and W-form select
//   in_a, in_b, in_tag  operands and opaque tag
//   out_valid/out_ready result handshake
//   out_result, out_tag registered result and its tag
module mul_pipelined
  import mul::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned WORD_OPS = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              in_op,
  input  logic             in_is_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PW = 2 * XLEN;

  logic             stall;
  logic             adv;
  logic             acc;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  // Only a full, unconsumed output stage stalls; every stage moves together.
  assign stall    = out_valid_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;
  assign acc      = in_valid & ~stall & ~flush;

  // Stage-0 signedness decode folded into the extended operands.
  logic [XLEN:0] a_ext;
  logic [XLEN:0] b_ext;
  ctrl_t         in_ctrl;

  assign a_ext           = {op_a_signed(in_op) & in_a[XLEN-1], in_a};
  assign b_ext           = {op_b_signed(in_op) & in_b[XLEN-1], in_b};
  assign in_ctrl.op      = in_op;
  assign in_ctrl.is_word = in_is_word;

  logic [PW-1:0] prod;

  mul_core #(
    .XLEN   (XLEN),
    .STAGES (STAGES)
  ) u_core (
    .clock  (clock),
    .en_i   (adv),
    .a_i    (a_ext),
    .b_i    (b_ext),
    .prod_o (prod)
  );

  // Control seen by the final stage, aligned with prod.
  logic             fin_valid;
  ctrl_t            fin_ctrl;
  logic [TAG_W-1:0] fin_tag;

  if (STAGES == 1) begin : g_no_chain
    assign fin_valid = acc;
    assign fin_ctrl  = in_ctrl;
    assign fin_tag   = in_tag;
  end else begin : g_chain
    localparam int unsigned D = STAGES - 1;

    logic [D-1:0]     vld_q;
    ctrl_t            ctrl_q [D];
    logic [TAG_W-1:0] tag_q  [D];

    // Valid chain; flush clears it, data registers are left alone.
    always_ff @(posedge clock) begin
      if (reset || flush) begin
        vld_q <= '0;
      end else if (adv) begin
        vld_q[0] <= acc;
        for (int unsigned i = 1; i < D; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // Control and tag shift in lockstep with the core registers.
    always_ff @(posedge clock) begin
      if (adv) begin
        ctrl_q[0] <= in_ctrl;
        tag_q[0]  <= in_tag;
        for (int unsigned i = 1; i < D; i++) begin
          ctrl_q[i] <= ctrl_q[i-1];
          tag_q[i]  <= tag_q[i-1];
        end
      end
    end

    assign fin_valid = vld_q[D-1];
    assign fin_ctrl  = ctrl_q[D-1];
    assign fin_tag   = tag_q[D-1];
  end

  // Result select and W-form sign extension.
  logic [XLEN-1:0] sel_c;
  logic [XLEN-1:0] word_c;
  logic [XLEN-1:0] res_c;

  assign sel_c = (fin_ctrl.op == MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];

  if (XLEN > 32) begin : g_wext
    assign word_c = {{(XLEN-32){sel_c[31]}}, sel_c[31:0]};
  end else begin : g_wnone
    assign word_c = sel_c;
  end

  assign res_c = ((WORD_OPS != 0) && fin_ctrl.is_word) ? word_c : sel_c;

  // Output stage: data and tag move only when a live op advances into it.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
    end else if (adv) begin
      out_valid_q <= fin_valid;
      if (fin_valid) begin
        out_result_q <= res_c;
        out_tag_q    <= fin_tag;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_mul_pipelined.sv
// Scoreboard bench for mul_pipelined: a 64-bit/3-stage instance with W ops and
// a 32-bit/1-stage instance without, driven from a table of hand-computed vectors.
module tb_mul_pipelined;
  import mul::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 64-bit, 3-stage instance
  logic        reset, flush, in_valid, in_ready, in_is_word, out_valid, out_ready;
  op_t         in_op;
  logic [63:0] in_a, in_b, out_result;
  logic [5:0]  in_tag, out_tag;

  // 32-bit, 1-stage instance
  logic        flush1, in_valid1, in_ready1, in_is_word1, out_valid1, out_ready1;
  op_t         in_op1;
  logic [31:0] in_a1, in_b1, out_result1;
  logic [5:0]  in_tag1, out_tag1;

  mul_pipelined #(.XLEN(64), .STAGES(3), .TAG_W(6), .WORD_OPS(1)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_is_word(in_is_word),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  mul_pipelined #(.XLEN(32), .STAGES(1), .TAG_W(6), .WORD_OPS(0)) dut1 (
    .clock(clock), .reset(reset), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op1), .in_is_word(in_is_word1),
    .in_a(in_a1), .in_b(in_b1), .in_tag(in_tag1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_result(out_result1), .out_tag(out_tag1)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [5:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t sb1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Directed vectors with hand-computed results
  localparam int NV = 14;
  op_t         v_op [NV];
  logic        v_w  [NV];
  logic [63:0] v_a  [NV];
  logic [63:0] v_b  [NV];
  logic [63:0] v_e  [NV];

  task automatic setv(input int i, input op_t op, input logic w,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
    v_op[i] = op; v_w[i] = w; v_a[i] = a; v_b[i] = b; v_e[i] = e;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Presents one table vector; pushes its expectation on the accepting edge.
  task automatic issue(input int vi, input logic [5:0] tag);
    bit ok;
    int n;
    in_valid = 1'b1; in_op = v_op[vi]; in_is_word = v_w[vi];
    in_a = v_a[vi]; in_b = v_b[vi]; in_tag = tag;
    ok = 1'b0; n = 0;
    while (!ok && n < 64) begin
      @(negedge clock);
      ok = (in_ready === 1'b1);
      @(posedge clock);
      n++;
    end
    if (ok) sb.push_back({v_e[vi], tag});
    else begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout tag=%0d: got in_ready=0 expected 1", tag);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic issue1(input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag, input logic [31:0] e);
    bit ok;
    int n;
    in_valid1 = 1'b1; in_op1 = op; in_a1 = a; in_b1 = b; in_tag1 = tag;
    ok = 1'b0; n = 0;
    while (!ok && n < 64) begin
      @(negedge clock);
      ok = (in_ready1 === 1'b1);
      @(posedge clock);
      n++;
    end
    if (ok) sb1.push_back({32'h0, e, tag});
    else begin
      n_cmp++; n_bad++;
      $display("FAIL issue1_timeout tag=%0d: got in_ready=0 expected 1", tag);
    end
    #1 in_valid1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || sb1.size() != 0) && n < 60) begin
      @(posedge clock);
      n++;
    end
    check("drain_sb", 64'(sb.size()), 64'd0);
    check("drain_sb1", 64'(sb1.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  // Monitor for the 64-bit instance: pops on transfer, checks hold while stalled.
  logic        held = 1'b0;
  logic [63:0] h_res;
  logic [5:0]  h_tag;
  always @(negedge clock) begin
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: got tag %0d result %h expected no output", out_tag, out_result);
      end else begin
        e = sb.pop_front();
        check("result", out_result, e.res);
        check("tag", 64'(out_tag), 64'(e.tag));
      end
      held = 1'b0;
    end else if (out_valid === 1'b1) begin
      if (held) begin
        check("hold_result", out_result, h_res);
        check("hold_tag", 64'(out_tag), 64'(h_tag));
      end
      held = 1'b1; h_res = out_result; h_tag = out_tag;
    end else begin
      held = 1'b0;
    end
  end

  // Monitor for the 32-bit instance.
  always @(negedge clock) begin
    exp_t e;
    if (out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
      if (sb1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out1: got tag %0d result %h expected no output", out_tag1, out_result1);
      end else begin
        e = sb1.pop_front();
        check("result1", 64'(out_result1), e.res);
        check("tag1", 64'(out_tag1), 64'(e.tag));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    setv(0,  MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    setv(1,  MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    setv(2,  MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    setv(3,  MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    setv(4,  MUL,    1'b1, 64'h4000_0000,           64'h2,                   64'hFFFF_FFFF_8000_0000);
    setv(5,  MULHU,  1'b1, 64'h8000_0000_0000_0000, 64'h4,                   64'h2);
    setv(6,  MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3,                   64'hFFFF_FFFF_FFFF_FFFA);
    setv(7,  MULHU,  1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
    setv(8,  MULH,   1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
    setv(9,  MULH,   1'b0, 64'h8000_0000_0000_0000, 64'h1,                   64'hFFFF_FFFF_FFFF_FFFF);
    setv(10, MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,                   64'hFFFF_FFFF_FFFF_FFFF);
    setv(11, MUL,    1'b0, 64'h1234_5678,           64'h10,                  64'h0000_0001_2345_6780);
    setv(12, MULHSU, 1'b0, 64'h2,                   64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    setv(13, MULHU,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = MUL; in_is_word = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    flush1 = 1'b0; in_valid1 = 1'b0; in_op1 = MUL; in_is_word1 = 1'b0;
    in_a1 = '0; in_b1 = '0; in_tag1 = '0; out_ready1 = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", out_result, 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;

    // MULHU all-ones with latency check: valid exactly two edges after accept
    issue(0, 6'd0);
    @(negedge clock); check("lat_edge0", 64'(out_valid), 64'd0);
    @(negedge clock); check("lat_edge1", 64'(out_valid), 64'd0);
    @(negedge clock); check("lat_edge2", 64'(out_valid), 64'd1);
    @(posedge clock); #1;

    // Back-to-back MUL/MULH/MULHSU
    issue(1, 6'd1); issue(2, 6'd2); issue(3, 6'd3);
    drain();

    // W forms
    issue(4, 6'd4); issue(5, 6'd5);
    drain();

    // 20-op stream with a 3-cycle consumer stall
    fork
      begin
        for (int i = 0; i < 20; i++) issue(i % NV, 6'(10 + i));
      end
      begin
        repeat (7) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with three ops in flight and a new op in the flush cycle
    out_ready = 1'b0;
    issue(6, 6'd40); issue(7, 6'd41); issue(8, 6'd42);
    in_valid = 1'b1; in_op = v_op[9]; in_is_word = v_w[9];
    in_a = v_a[9]; in_b = v_b[9]; in_tag = 6'd43; flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clock); check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_valid0", 64'(out_valid), 64'd0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clock); check("flush_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clock); #1 out_ready = 1'b1;
    issue(10, 6'd44);
    drain();

    // 32-bit, single-stage instance: MULHU then MUL/MULH/MULHSU
    issue1(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd60, 32'hFFFF_FFFE);
    @(negedge clock); check("lat1_edge0", 64'(out_valid1), 64'd1);
    @(posedge clock); #1;
    issue1(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd61, 32'h1);
    issue1(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd62, 32'h0);
    issue1(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd63, 32'hFFFF_FFFF);
    drain();

    // Reset with the pipe full and the consumer stalled
    out_ready = 1'b0;
    issue(11, 6'd50); issue(12, 6'd51); issue(13, 6'd52);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0; out_ready = 1'b1;
    sb.delete();
    @(negedge clock);
    check("rst2_valid", 64'(out_valid), 64'd0);
    check("rst2_result", out_result, 64'd0);
    check("rst2_tag", 64'(out_tag), 64'd0);
    check("rst2_result1", 64'(out_result1), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); check("rst2_idle", 64'(out_valid), 64'd0);
    end
    @(posedge clock); #1;
    issue(7, 6'd53);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
